mips_multicycle_datapath: RTL and testbench
===========================================

MIPS_MULTICYCLE_DATAPATH -- requirements
Module: mips_multicycle_datapath

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have control inputs, all 1 bit: MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCWriteCond, PCWrite, IorD.
REQ-004 The block SHALL have control inputs ALUSrcB (3 bits), ALUOp (2 bits) and PCSource (2 bits).
REQ-005 The block SHALL have port Op_code, output, 6 bits: IR[31:26], returned to the control module.
REQ-006 The block SHALL have port Zero, output, 1 bit: the current ALU result equals 0.
REQ-007 The block SHALL have the memory ports mem_addr (output, 32), mem_wdata (output, 32), mem_we (output, 1) and mem_rdata (input, 32, combinational read of mem_addr).
REQ-008 The block SHALL have port pc_out, output, 32 bits: the current PC, for debug.

Function
REQ-009 Registers SHALL be PC, IR, MDR, A, B and ALUOut (each 32 bits), plus a 32x32 register file.
REQ-010 mem_addr SHALL be PC when IorD=0 and ALUOut when IorD=1; mem_wdata SHALL be B; mem_we SHALL be MemWrite.
REQ-011 IR SHALL load mem_rdata only on a cycle with IRWrite=1; otherwise IR holds.
REQ-012 MDR SHALL load mem_rdata every cycle.
REQ-013 A SHALL load rf[IR[25:21]] every cycle, B SHALL load rf[IR[20:16]] every cycle, and ALUOut SHALL load the ALU result every cycle.
REQ-014 ALU input A SHALL be PC when ALUSrcA=0 and register A when ALUSrcA=1.
REQ-015 ALU input B SHALL be selected by ALUSrcB: 000 B; 001 constant 4; 010 sign-extended IR[15:0]; 011 sign-extended IR[15:0]<<2; 100 zero-extended IR[15:0]; 101-111 zero.
REQ-016 ALU operation SHALL follow ALUOp: 00 add; 01 subtract (A-B); 11 OR.
REQ-017 ALUOp=10 SHALL decode funct IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0); any other funct gives a result of 0.
REQ-018 Add and subtract SHALL be 32-bit modulo, with overflow ignored.
REQ-019 The register-file write address SHALL be IR[20:16] when RegDst=0 and IR[15:11] when RegDst=1.
REQ-020 The register-file write data SHALL be ALUOut when MemtoReg=0 and MDR when MemtoReg=1.
REQ-021 Register-file writes SHALL occur on a clock edge with RegWrite=1.
REQ-022 Register 0 SHALL always read 0, and writes to register 0 SHALL be discarded.
REQ-023 A register-file read of a register written on the same edge SHALL return the old value; the new value is visible to the A/B capture on the next edge.
REQ-024 The next-PC source SHALL be selected by PCSource: 00 ALU result (combinational); 01 ALUOut; 10 {PC[31:28], IR[25:0], 2'b00}; 11 current PC.
REQ-025 PC SHALL update when PCWrite=1, or when PCWriteCond=1 and Zero=1.
REQ-026 PCWrite and PCWriteCond both high SHALL behave as PCWrite=1.
REQ-027 Zero SHALL be combinational from the current-cycle ALU result, not from ALUOut.
REQ-028 Op_code SHALL change only on the edge after an IRWrite cycle, giving one cycle of latency from a fetch to the decode state.

Reset
REQ-029 While rst=1, PC, IR, MDR, A, B, ALUOut and all 32 registers SHALL be 0, independent of clk.
REQ-030 While rst=1, Op_code=0, pc_out=0 and mem_addr=0 when IorD=0.
REQ-031 While rst=1, mem_we SHALL follow MemWrite unmodified; the control module is responsible for holding MemWrite=0.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction; no partial register or PC update SHALL survive.
REQ-033 After rst falls, the first rising edge SHALL perform normal updates.

Verification
REQ-034 Fetch: PC=0, mem_rdata=0x8C220004, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=001, ALUOp=00, PCSource=00, PCWrite=1 -> after one edge, IR=0x8C220004, Op_code=0x23, PC=4.
REQ-035 R-type add: rf[1]=5, rf[2]=7, IR=0x00221820 -> decode, then execute (ALUSrcA=1, ALUSrcB=000, ALUOp=10), then writeback (RegDst=1, RegWrite=1) -> rf[3]=12; rf[0] remains 0 when the destination is $0.
REQ-036 Load/store: rf[1]=0x100, lw offset 4, mem_rdata=0xDEADBEEF at IorD=1 -> rf[2]=0xDEADBEEF; sw with rf[2]=0x55 -> mem_addr=0x104, mem_wdata=0x55, mem_we=1 for exactly one cycle.
REQ-037 Branch: beq with rf[1]=rf[2], offset 3, PC=8 -> ALUOut=8+12=20, PCWriteCond=1, PCSource=01 -> PC=20; with unequal registers -> PC stays 8.
REQ-038 Jump: PC=0x40000010, IR=0x08000004, PCSource=10, PCWrite=1 -> PC=0x40000010.
REQ-039 Mid-instruction reset: assert rst asynchronously between edges during writeback -> PC=0, IR=0 and registers 0 immediately; the target register is not written.

Source files
------------

// File: rtl/mips_multicycle_datapath.sv
// mips_multicycle_datapath: multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, 32x32 register file)
// driven cycle by cycle by an external control FSM.
module mips_multicycle_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        MemtoReg,
    input  logic        RegDst,
    input  logic        RegWrite,
    input  logic        ALUSrcA,
    input  logic        PCWriteCond,
    input  logic        PCWrite,
    input  logic        IorD,
    input  logic [2:0]  ALUSrcB,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  PCSource,
    output logic [5:0]  Op_code,
    output logic        Zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [31:0] imm_s, src_a, src_b, alu_res, pc_next, wr_data;
    logic [4:0]  wr_addr;
    logic        pc_en;

    assign Op_code   = ir_q[31:26];
    assign pc_out    = pc_q;
    assign mem_addr  = IorD ? alu_out_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = MemWrite;
    assign Zero      = alu_res == 32'd0;

    always_comb begin
        imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
        src_a = ALUSrcA ? a_q : pc_q;
        case (ALUSrcB)
            3'b000:  src_b = b_q;
            3'b001:  src_b = 32'd4;
            3'b010:  src_b = imm_s;
            3'b011:  src_b = {imm_s[29:0], 2'b00};
            3'b100:  src_b = {16'd0, ir_q[15:0]};
            default: src_b = 32'd0;
        endcase
        case (ALUOp)
            2'b00: alu_res = src_a + src_b;
            2'b01: alu_res = src_a - src_b;
            2'b11: alu_res = src_a | src_b;
            default:
                case (ir_q[5:0])
                    6'h20:   alu_res = src_a + src_b;
                    6'h22:   alu_res = src_a - src_b;
                    6'h24:   alu_res = src_a & src_b;
                    6'h25:   alu_res = src_a | src_b;
                    6'h2a:   alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
                    default: alu_res = 32'd0;
                endcase
        endcase
    end

    always_comb begin
        pc_next = PCSource == 2'b00 ? alu_res :
                  PCSource == 2'b01 ? alu_out_q :
                  PCSource == 2'b10 ? {pc_q[31:28], ir_q[25:0], 2'b00} : pc_q;
        pc_en     = PCWrite | (PCWriteCond & Zero);
        pc_d      = pc_en ? pc_next : pc_q;
        ir_d      = IRWrite ? mem_rdata : ir_q;
        mdr_d     = mem_rdata;
        a_d       = rf_q[ir_q[25:21]];
        b_d       = rf_q[ir_q[20:16]];
        alu_out_d = alu_res;
        wr_addr   = RegDst ? ir_q[15:11] : ir_q[20:16];
        wr_data   = MemtoReg ? mdr_q : alu_out_q;
        rf_d      = rf_q;
        // register 0 is never written, so its read is always 0
        if (RegWrite && wr_addr != 5'd0)
            rf_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            rf_q      <= rf_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb_mips_multicycle_datapath: directed-vector bench for the multicycle datapath;
// register contents are observed through B -> mem_wdata and ALUOut -> mem_addr.
module tb_mips_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic        PCWriteCond, PCWrite, IorD;
    logic [2:0]  ALUSrcB;
    logic [1:0]  ALUOp, PCSource;
    logic [5:0]  Op_code;
    logic        Zero, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [5:0]  fn [6] = '{6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h27};
    logic [31:0] fx [6] = '{32'hFFFFFFFE, 32'd5, 32'd7, 32'd1, 32'd0, 32'd0};

    always #5 clk = ~clk;

    mips_multicycle_datapath dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWriteCond(PCWriteCond),
        .PCWrite(PCWrite), .IorD(IorD), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Op_code(Op_code), .Zero(Zero), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .pc_out(pc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'd0, rs, rt, rd, 5'd0, f};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        {MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCWriteCond, PCWrite, IorD} = '0;
        ALUSrcB = 3'd0;
        ALUOp = 2'd0;
        PCSource = 2'd0;
    endtask

    // load IR, then one more edge so A/B hold rf[rs]/rf[rt]
    task automatic load_ir(input logic [31:0] ins);
        idle();
        mem_rdata = ins;
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        step();
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        idle();
        mem_rdata = {6'h23, 5'd0, r, 16'd0};
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        mem_rdata = v;
        step();
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        step();
        idle();
    endtask

    task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        load_ir({6'h2b, 5'd0, r, 16'd0});
        check(tag, mem_wdata, exp);
    endtask

    task automatic alu_out_is(input string tag, input logic [31:0] exp);
        IorD = 1'b1;
        #1;
        check(tag, mem_addr, exp);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        MemWrite = 1'b1;
        mem_rdata = 32'h12345678;
        #3;
        check("rst_pc", pc_out, 32'd0);
        check("rst_op", {26'd0, Op_code}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd1);
        MemWrite = 1'b0;
        PCWrite = 1'b1;
        ALUSrcB = 3'd1;
        IRWrite = 1'b1;
        step();
        check("rst_hold_pc", pc_out, 32'd0);
        check("rst_hold_op", {26'd0, Op_code}, 32'd0);
        rst = 1'b0;

        idle();
        mem_rdata = 32'h8C220004;
        IRWrite = 1'b1;
        ALUSrcB = 3'd1;
        PCWrite = 1'b1;
        #1;
        check("fetch_op_pre", {26'd0, Op_code}, 32'd0);
        check("fetch_zero", {31'd0, Zero}, 32'd0);
        step();
        check("fetch_op", {26'd0, Op_code}, 32'h23);
        check("fetch_pc", pc_out, 32'd4);

        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd7);
        load_ir(32'h00221820);
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        #1;
        check("add_zero", {31'd0, Zero}, 32'd0);
        step();
        alu_out_is("add_aluout", 32'd12);
        RegDst = 1'b1;
        RegWrite = 1'b1;
        step();
        idle();
        read_reg("add_rf3", 5'd3, 32'd12);

        load_ir(rtype(5'd1, 5'd2, 5'd0, 6'h20));
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        step();
        idle();
        RegDst = 1'b1;
        RegWrite = 1'b1;
        step();
        idle();
        read_reg("r0_stays0", 5'd0, 32'd0);

        for (int i = 0; i < 6; i++) begin
            load_ir(rtype(5'd1, 5'd2, 5'd3, fn[i]));
            ALUSrcA = 1'b1;
            ALUOp = 2'b10;
            #1;
            check($sformatf("fn%02h_zero", fn[i]), {31'd0, Zero}, {31'd0, fx[i] == 32'd0});
            step();
            alu_out_is($sformatf("fn%02h_res", fn[i]), fx[i]);
        end

        write_reg(5'd4, 32'hFFFFFFFF);
        load_ir(rtype(5'd4, 5'd1, 5'd3, 6'h2a));
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        step();
        alu_out_is("slt_neg_lt", 32'd1);
        load_ir(rtype(5'd1, 5'd4, 5'd3, 6'h2a));
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        step();
        alu_out_is("slt_pos_gt", 32'd0);

        load_ir(32'h34208000);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd4;
        ALUOp = 2'b11;
        step();
        alu_out_is("zext_or", 32'h00008005);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd2;
        step();
        alu_out_is("sext_add", 32'hFFFF8005);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd3;
        step();
        alu_out_is("sext_sh2", 32'hFFFE0005);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd7;
        step();
        alu_out_is("srcb_zero", 32'd5);

        write_reg(5'd1, 32'h100);
        load_ir(32'h8C220004);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd2;
        step();
        alu_out_is("lw_addr", 32'h104);
        IorD = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        idle();
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        step();
        idle();
        read_reg("lw_rf2", 5'd2, 32'hDEADBEEF);

        write_reg(5'd2, 32'h55);
        load_ir(32'hAC220004);
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd2;
        step();
        idle();
        IorD = 1'b1;
        MemWrite = 1'b1;
        #1;
        check("sw_addr", mem_addr, 32'h104);
        check("sw_wdata", mem_wdata, 32'h55);
        check("sw_we", {31'd0, mem_we}, 32'd1);
        step();
        idle();
        #1;
        check("sw_we_off", {31'd0, mem_we}, 32'd0);

        ALUSrcB = 3'd1;
        PCWrite = 1'b1;
        step();
        idle();
        check("pc_to_8", pc_out, 32'd8);
        write_reg(5'd1, 32'd9);
        write_reg(5'd2, 32'd9);
        load_ir(32'h10220003);
        ALUSrcB = 3'd3;
        step();
        alu_out_is("beq_target", 32'd20);
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        #1;
        check("beq_zero", {31'd0, Zero}, 32'd1);
        step();
        idle();
        check("beq_taken", pc_out, 32'd20);

        write_reg(5'd5, 32'd8);
        load_ir(rtype(5'd5, 5'd0, 5'd0, 6'h00));
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd5;
        step();
        idle();
        PCWrite = 1'b1;
        PCSource = 2'b01;
        step();
        idle();
        check("pc_back_8", pc_out, 32'd8);
        write_reg(5'd2, 32'd3);
        load_ir(32'h10220003);
        ALUSrcB = 3'd3;
        step();
        idle();
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        #1;
        check("bne_zero", {31'd0, Zero}, 32'd0);
        step();
        idle();
        check("beq_not_taken", pc_out, 32'd8);
        ALUSrcB = 3'd1;
        PCWrite = 1'b1;
        PCWriteCond = 1'b1;
        step();
        idle();
        check("pcw_and_cond", pc_out, 32'd12);

        write_reg(5'd5, 32'h40000010);
        load_ir(rtype(5'd5, 5'd0, 5'd0, 6'h00));
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd5;
        step();
        idle();
        PCWrite = 1'b1;
        PCSource = 2'b01;
        step();
        check("pc_hi", pc_out, 32'h40000010);
        load_ir(32'h08000004);
        PCWrite = 1'b1;
        PCSource = 2'b10;
        step();
        check("jump_a", pc_out, 32'h40000010);
        load_ir(32'h08000100);
        PCWrite = 1'b1;
        PCSource = 2'b10;
        step();
        check("jump_b", pc_out, 32'h40000400);
        idle();
        PCWrite = 1'b1;
        PCSource = 2'b11;
        step();
        check("pcsrc_hold", pc_out, 32'h40000400);

        idle();
        mem_rdata = {6'h23, 5'd0, 5'd6, 16'd0};
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        mem_rdata = 32'h77;
        step();
        check("wb_op", {26'd0, Op_code}, 32'h23);
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 3'd1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_pc", pc_out, 32'd0);
        check("mid_rst_op", {26'd0, Op_code}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        step();
        rst = 1'b0;
        idle();
        mem_rdata = 32'h8C220004;
        IRWrite = 1'b1;
        ALUSrcB = 3'd1;
        PCWrite = 1'b1;
        step();
        check("post_rst_pc", pc_out, 32'd4);
        check("post_rst_op", {26'd0, Op_code}, 32'h23);
        read_reg("mid_rst_rf6", 5'd6, 32'd0);
        read_reg("mid_rst_rf1", 5'd1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
